// File: rtl/div_clk_meter_pkg.sv
// Shared types and constants for the divided-clock meter.
package div_clk_meter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        TOUT = 2'd2
    } meter_state_t;

    localparam int CNT_W_DEF       = 16;
    localparam int SYNC_STAGES_DEF = 2;
    localparam int LOCK_COUNT_DEF  = 4;

    // All-ones pattern; truncated to the counter width it becomes the saturation value.
    localparam logic [63:0] CNT_SAT_ALL = '1;

endpackage

// File: rtl/div_clk_meter_sync_edge.sv
// Multi-flop synchroniser for an asynchronous level plus rise/fall detection
// on the synchronised bit. Reusable for any asynchronous input.
module sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   dly_q, dly_d;

    // Shift the input through the synchroniser chain and keep one delayed copy.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], din};
        dly_d  = sync_q[SYNC_STAGES-1];
    end

    // Synchroniser and delay flops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
            dly_q  <= 1'b0;
        end else begin
            sync_q <= sync_d;
            dly_q  <= dly_d;
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~dly_q;
    assign fall  = ~level & dly_q;

endmodule

// File: rtl/div_clk_meter.sv
// Divided-clock meter: measures div_clk period and high time in clk cycles,
// flags timeout when no rising edge arrives before the period counter saturates.
// Optional lock detection is built when DIV_CLK_METER_LOCK_EN is defined.
module div_clk_meter
    import div_clk_meter_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int LOCK_COUNT  = LOCK_COUNT_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             div_clk,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             timeout,
    output logic             locked
);

    localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(CNT_SAT_ALL);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    if (SYNC_STAGES < 2 || LOCK_COUNT < 1) begin : g_bad_param
        $error("div_clk_meter: SYNC_STAGES must be >= 2 and LOCK_COUNT >= 1");
    end

    logic div_lvl, div_rise, div_fall;

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .reset (reset),
        .din   (div_clk),
        .level (div_lvl),
        .rise  (div_rise),
        .fall  (div_fall)
    );

    meter_state_t     state_q, state_d;
    logic [CNT_W-1:0] pcnt_q, pcnt_d;
    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    logic [CNT_W-1:0] hi_hold_q, hi_hold_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] high_time_q, high_time_d;
    logic             meas_valid_q, meas_valid_d;
    logic             timeout_q, timeout_d;
    logic             publish, tout_set, tout_clr;

    // Saturating period/high counters restarted on each rise; high count held at fall.
    always_comb begin
        pcnt_d    = pcnt_q;
        hcnt_d    = hcnt_q;
        hi_hold_d = hi_hold_q;
        if (div_rise) begin
            pcnt_d = CNT_ONE;
            hcnt_d = CNT_ONE;
        end else begin
            if (pcnt_q != CNT_SAT) pcnt_d = pcnt_q + 1'b1;
            if (div_lvl && hcnt_q != CNT_SAT) hcnt_d = hcnt_q + 1'b1;
        end
        if (div_fall) hi_hold_d = hcnt_q;
    end

    // Next state and publish/timeout decisions; a rise always beats saturation.
    always_comb begin
        state_d  = state_q;
        publish  = 1'b0;
        tout_set = 1'b0;
        tout_clr = 1'b0;
        case (state_q)
            IDLE: if (div_rise) state_d = RUN;
            RUN: begin
                if (div_rise) begin
                    publish = 1'b1;
                end else if (pcnt_q == CNT_SAT) begin
                    state_d  = TOUT;
                    tout_set = 1'b1;
                end
            end
            TOUT: begin
                if (div_rise) begin
                    state_d  = RUN;
                    tout_clr = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output register next values: measurements update only on publish.
    always_comb begin
        period_d     = publish ? pcnt_q : period_q;
        high_time_d  = publish ? hi_hold_q : high_time_q;
        meas_valid_d = publish;
        timeout_d    = timeout_q;
        if (tout_set) timeout_d = 1'b1;
        else if (tout_clr) timeout_d = 1'b0;
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Counters and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pcnt_q       <= '0;
            hcnt_q       <= '0;
            hi_hold_q    <= '0;
            period_q     <= '0;
            high_time_q  <= '0;
            meas_valid_q <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            pcnt_q       <= pcnt_d;
            hcnt_q       <= hcnt_d;
            hi_hold_q    <= hi_hold_d;
            period_q     <= period_d;
            high_time_q  <= high_time_d;
            meas_valid_q <= meas_valid_d;
            timeout_q    <= timeout_d;
        end
    end

    assign period     = period_q;
    assign high_time  = high_time_q;
    assign meas_valid = meas_valid_q;
    assign timeout    = timeout_q;

`ifdef DIV_CLK_METER_LOCK_EN
    localparam int                LOCK_W   = $clog2(LOCK_COUNT + 1);
    localparam logic [LOCK_W-1:0] LOCK_MAX = LOCK_W'(LOCK_COUNT);

    logic [LOCK_W-1:0] lock_cnt_q, lock_cnt_d;

    // Count consecutive publishes repeating the previous period; timeout or mismatch clears.
    always_comb begin
        lock_cnt_d = lock_cnt_q;
        if (tout_set) begin
            lock_cnt_d = '0;
        end else if (publish) begin
            if (pcnt_q == period_q) begin
                if (lock_cnt_q != LOCK_MAX) lock_cnt_d = lock_cnt_q + 1'b1;
            end else begin
                lock_cnt_d = '0;
            end
        end
    end

    // Lock counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) lock_cnt_q <= '0;
        else        lock_cnt_q <= lock_cnt_d;
    end

    assign locked = (lock_cnt_q == LOCK_MAX);
`else
    assign locked = 1'b0;
`endif

endmodule

// File: tb/tb_div_clk_meter.sv
// Scoreboard bench for div_clk_meter: stimulus pushes expected publishes derived
// from the driven div_clk waveform; an independent monitor pops and compares.
module tb_div_clk_meter;

    localparam int CNT_W = 4;
    localparam int SAT   = (1 << CNT_W) - 1;
    localparam int LOCK  = 4;
`ifdef DIV_CLK_METER_LOCK_EN
    localparam bit LOCK_ON = 1'b1;
`else
    localparam bit LOCK_ON = 1'b0;
`endif

    logic             clk;
    logic             reset;
    logic             div_clk;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             meas_valid;
    logic             timeout;
    logic             locked;

    div_clk_meter #(.CNT_W(CNT_W), .SYNC_STAGES(2), .LOCK_COUNT(LOCK)) dut (
        .clk        (clk),
        .reset      (reset),
        .div_clk    (div_clk),
        .period     (period),
        .high_time  (high_time),
        .meas_valid (meas_valid),
        .timeout    (timeout),
        .locked     (locked)
    );

    typedef struct {
        int p;
        int h;
        bit l;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model state, expressed in whole div_clk periods.
    bit have_prev = 1'b0;
    bit timed     = 1'b0;
    int gap       = 0;
    int cur_h     = 0;
    int last_pub  = 0;
    int match_run = 0;
    int exp_tout  = 0;
    int tout_seen = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        have_prev = 1'b0;
        timed     = 1'b0;
        gap       = 0;
        last_pub  = 0;
        match_run = 0;
    endtask

    // A rising edge of div_clk: completes the previous period if one was being timed.
    task automatic model_rise();
        exp_t e;
        if (have_prev && !timed) begin
            if (gap == last_pub) match_run = (match_run < LOCK) ? match_run + 1 : LOCK;
            else                 match_run = 0;
            last_pub = gap;
            e.p = gap;
            e.h = cur_h;
            e.l = LOCK_ON && (match_run == LOCK);
            sb.push_back(e);
        end
        have_prev = 1'b1;
        timed     = 1'b0;
        gap       = 0;
    endtask

    // One clk cycle elapses; a period longer than the counter range is a timeout.
    task automatic tick();
        @(posedge clk);
        #1;
        gap++;
        if (have_prev && !timed && gap > SAT) begin
            timed     = 1'b1;
            exp_tout++;
            match_run = 0;
        end
    endtask

    task automatic drive_period(input int h, input int l);
        model_rise();
        cur_h   = h;
        div_clk = 1'b1;
        repeat (h) tick();
        div_clk = 1'b0;
        repeat (l) tick();
    endtask

    // Monitor: compares every publish against the scoreboard and times the timeout flag.
    initial begin
        exp_t e;
        int   cyc;
        int   last_mv_cyc;
        bit   prev_tout;
        cyc         = 0;
        last_mv_cyc = 0;
        prev_tout   = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset === 1'b1) begin
                if (meas_valid === 1'b1) begin
                    chk("publish_expected", sb.size() != 0, 1);
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                        chk("period", period, e.p);
                        chk("high_time", high_time, e.h);
                        chk("locked", locked, e.l);
                        chk("timeout_at_publish", timeout, 0);
                    end
                    last_mv_cyc = cyc;
                end
                if (timeout === 1'b1 && !prev_tout) begin
                    tout_seen++;
                    chk("timeout_delay", cyc - last_mv_cyc, SAT);
                    chk("locked_at_timeout", locked, 0);
                end
                prev_tout = (timeout === 1'b1);
            end else begin
                prev_tout = 1'b0;
            end
        end
    end

    initial begin
        int h, l;
        reset   = 1'b0;
        div_clk = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_period", period, 0);
        chk("rst_high_time", high_time, 0);
        chk("rst_meas_valid", meas_valid, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_locked", locked, 0);
        #3 reset = 1'b1;
        repeat (3) tick();

        // 5 high / 5 low, then duty change to 3 / 7.
        repeat (6) drive_period(5, 5);
        repeat (3) drive_period(3, 7);

        // Long low phase forces a timeout, then resume.
        drive_period(5, 20);
        repeat (4) drive_period(5, 5);

        // Steady period 8, one 9-cycle period, steady again.
        repeat (7) drive_period(4, 4);
        drive_period(5, 4);
        repeat (5) drive_period(4, 4);

        // Asynchronous reset in the middle of a period.
        model_rise();
        cur_h   = 4;
        div_clk = 1'b1;
        repeat (4) tick();
        div_clk = 1'b0;
        repeat (3) tick();
        #3 reset = 1'b0;
        #1;
        chk("mid_rst_period", period, 0);
        chk("mid_rst_high_time", high_time, 0);
        chk("mid_rst_meas_valid", meas_valid, 0);
        chk("mid_rst_timeout", timeout, 0);
        chk("mid_rst_locked", locked, 0);
        chk("sb_drained_at_reset", sb.size(), 0);
        model_reset();
        tick();
        #3 reset = 1'b1;
        repeat (2) tick();

        // Minimum ratio, then the longest period that still fits the counter.
        repeat (8) drive_period(1, 1);
        repeat (3) drive_period(8, 7);

        // Randomised periods.
        for (int i = 0; i < 40; i++) begin
            h = int'($urandom_range(7, 1));
            l = int'($urandom_range(7, 1));
            drive_period(h, l);
        end

        // Final hold low ends in a timeout.
        repeat (30) tick();
        repeat (3) @(posedge clk);
        #1;
        chk("sb_empty_at_end", sb.size(), 0);
        chk("timeout_count", tout_seen, exp_tout);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/div_clk_meter.md
# div_clk_meter

Measures a divided clock in the `clk` domain. `div_clk`, as produced by the clock divider, is synchronised into `clk`, and its rising and falling edges are detected. The block counts `clk` cycles per `div_clk` period and per high phase, and publishes each completed measurement with a one-cycle valid strobe. It sits beside the clock divider as its checker: the divider produces `div_clk`, and this block recovers the ratio and reports lock or timeout.

## Interface
Parameters:
- `CNT_W`, 16: width of the period and high-time counters and outputs.
- `SYNC_STAGES`, 2: synchroniser flops on `div_clk`; minimum 2.
- `LOCK_COUNT`, 4: number of consecutive equal periods needed for lock (only used with lock enabled).

Ports:
- `clk`, input, 1: sole clock. All logic is rising-edge.
- `reset`, input, 1: asynchronous, active-low. 0 clears all state immediately.
- `div_clk`, input, 1: measured signal. Treated as asynchronous.
- `period`, output, CNT_W: last published period in `clk` cycles. Reset value 0.
- `high_time`, output, CNT_W: last published high-phase length in `clk` cycles. Reset value 0.
- `meas_valid`, output, 1: one-cycle strobe in the cycle `period` and `high_time` update. Reset value 0.
- `timeout`, output, 1: sticky; no rising edge within 2^CNT_W−1 cycles. Reset value 0.
- `locked`, output, 1: lock indicator. Reset value 0.

## Operation
- **Sync and edge detect:** `div_clk` passes through `SYNC_STAGES` flops, then one delay flop.
  - `rise` = synced & ~delayed.
  - `fall` = ~synced & delayed.
- **Period counter `pcnt`:** loads 1 in a `rise` cycle, otherwise increments. It saturates at all-ones and never wraps.
- **High counter `hcnt`:** loads 1 on `rise` and increments while synced is high. On `fall`, `hcnt` is captured into an internal `hi_hold`.
- **States:** IDLE, RUN, TOUT. Reset goes to IDLE.
  - IDLE, on `rise`: go to RUN. Nothing is published, because the first period is incomplete.
  - RUN, on `rise`: publish `period<=pcnt` and `high_time<=hi_hold`, pulse `meas_valid`, stay in RUN.
  - RUN, when `pcnt` reaches all-ones with no `rise`: go to TOUT. Set `timeout`=1 and clear `locked`. Outputs hold their previous values.
  - TOUT, on `rise`: go to RUN, clear `timeout`, restart the counters. Nothing is published.
- **Simultaneous `rise` and saturation in the same cycle:** `rise` wins. The saturated value is published, and the state stays in or returns to RUN.
- `rise` and `fall` never coincide, because both come from the single synced bit.
- **Reset asserted mid-measurement:** all outputs return to their reset values immediately. The next `rise` behaves as the first edge from IDLE.

## Timing
- `div_clk` edge to `rise`/`fall` detect: `SYNC_STAGES`+1 `clk` cycles.
- `rise` detect to `meas_valid` and updated outputs: 1 cycle (registered).
- `meas_valid` is high for exactly 1 cycle per published period. `period` and `high_time` hold between strobes.
- Steady `div_clk` with period P `clk` cycles: `meas_valid` pulses every P cycles.
- Minimum measurable: P=2, high=1. Any shorter pulse is lost in the synchroniser. This is not an error.

## Configuration
- **`DIV_CLK_METER_LOCK_EN` defined:** an equality comparator and a lock counter are instantiated.
  - Each publish with `period` equal to the previous published value increments the counter, saturating at `LOCK_COUNT`.
  - A mismatch resets the counter to 0, and `locked` drops in that same publish cycle.
  - `locked`=1 while counter == `LOCK_COUNT`.
  - Timeout clears the counter.
- **Not defined:** no comparator or counter; `locked` is tied to 0.

## Structure
- **Package `div_clk_meter_pkg`:**
  - state enum `meter_state_t` (IDLE, RUN, TOUT);
  - localparam for the all-ones saturation value;
  - `LOCK_COUNT` default.
- **Sub-module `sync_edge`:** parameter `SYNC_STAGES`; ports `clk`, `reset`, `din`; outputs `level`, `rise`, `fall`. It is reused for any other asynchronous input.
- The top level holds the counters, the state machine, the output registers and the optional lock logic.

## Test plan
- Reset, then a 10-cycle `div_clk` (5 high, 5 low): the first `rise` publishes nothing; afterwards there is `meas_valid` every 10 cycles with `period`=10 and `high_time`=5.
- Duty change to 3 high / 7 low mid-stream: the next publish gives `period`=10, `high_time`=3.
- Hold `div_clk` low with `CNT_W`=4: `timeout`=1 exactly 15 cycles after the last `rise` count restart, and `locked`=0. Resume toggling: `timeout` clears on the first `rise` and there is no publish until the second.
- Lock enabled, `LOCK_COUNT`=4, steady period 8:
  - `locked` rises on the 5th publish (4 consecutive matches);
  - a single 9-cycle period drops `locked` in that publish cycle.
- Drive `reset`=0 asynchronously between `clk` edges mid-period: all outputs read 0 before the next `clk` edge, and the first `rise` after release publishes nothing.
- Minimum ratio, period 2 (1 high, 1 low): `period`=2, `high_time`=1 on every publish.
